// File: rtl/sram_coord_arbiter_pkg.sv
// Shared types and constants for the SRAM coordinate arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WR,
        S_REC,
        S_RD1,
        S_RD2
    } state_e;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int ADDR_W    = 20;
    localparam int COORD_W   = 13;
    localparam int PROD_W    = 26;

endpackage

// File: rtl/sram_coord_arbiter_if.sv
// Requester-side handshake bundle: frame-save writer and readback reader.
import sram_arb_pkg::*;

interface sram_coord_arbiter_if #(
    parameter int DATA_W = 16
);
    logic               iWR_REQ;
    logic [COORD_W-1:0] iWR_X;
    logic [COORD_W-1:0] iWR_Y;
    logic [DATA_W-1:0]  iWR_DATA;
    logic               oWR_ACK;
    logic               iRD_REQ;
    logic [COORD_W-1:0] iRD_X;
    logic [COORD_W-1:0] iRD_Y;
    logic               oRD_ACK;
    logic [DATA_W-1:0]  oRD_DATA;
    logic               oRANGE_ERR;
    logic               oBUSY;

    modport master (
        output iWR_REQ, iWR_X, iWR_Y, iWR_DATA,
        output iRD_REQ, iRD_X, iRD_Y,
        input  oWR_ACK, oRD_ACK, oRD_DATA,
        input  oRANGE_ERR, oBUSY
    );

    modport slave (
        input  iWR_REQ, iWR_X, iWR_Y, iWR_DATA,
        input  iRD_REQ, iRD_X, iRD_Y,
        output oWR_ACK, oRD_ACK, oRD_DATA,
        output oRANGE_ERR, oBUSY
    );

endinterface

// File: rtl/sram_coord_arbiter_calc.sv
// Registered (X,Y) -> linear address conversion with range flag.
import sram_arb_pkg::*;

module coord_addr_calc #(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               range_err_o
);

    logic [PROD_W-1:0] prod_d;
    logic [ADDR_W-1:0] addr_d;
    logic              err_d;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    // Full-width product first, truncation only after the add.
    always_comb begin
        prod_d = PROD_W'(y_i) * PROD_W'(H_RES);
        addr_d = ADDR_W'(prod_d + PROD_W'(x_i));
        err_d  = (32'(x_i) >= 32'(H_RES)) || (32'(y_i) >= 32'(V_RES));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else if (en_i) begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign addr_o      = addr_q;
    assign range_err_o = err_q;

endmodule

// File: rtl/sram_coord_arbiter.sv
// Arbitrates writer/reader onto one SRAM and sequences its strobes.
// SRAM_ARB_RR_EN selects round-robin grant; default is write priority.
import sram_arb_pkg::*;

module sram_coord_arbiter #(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int DATA_W = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    sram_coord_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]     oSRAM_ADDR,
    inout  wire  [DATA_W-1:0]     ioSRAM_DQ,
    output logic                  oSRAM_WE_N,
    output logic                  oSRAM_OE_N,
    output logic                  oSRAM_CE_N,
    output logic                  oSRAM_LB_N,
    output logic                  oSRAM_UB_N
);

    state_e             state_q;
    logic               dir_wr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_n_q;
    logic               oe_n_q;
    logic               ce_n_q;
    logic               dq_oe_q;
    logic               wr_ack_q;
    logic               rd_ack_q;
`ifdef SRAM_ARB_RR_EN
    logic               last_rd_q;
`endif

    logic               rd_ok_d;
    logic               gnt_wr_d;
    logic               gnt_any_d;
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_d;
    logic               calc_en_d;
    logic [ADDR_W-1:0]  calc_addr;
    logic               calc_err;
    logic               err_ack;

    // The reader still holds its request while its ack is shown in IDLE.
    always_comb begin
        rd_ok_d   = bus.iRD_REQ & ~rd_ack_q;
`ifdef SRAM_ARB_RR_EN
        gnt_wr_d  = bus.iWR_REQ & (~rd_ok_d | last_rd_q);
`else
        gnt_wr_d  = bus.iWR_REQ;
`endif
        gnt_any_d = bus.iWR_REQ | rd_ok_d;
        x_d       = gnt_wr_d ? bus.iWR_X : bus.iRD_X;
        y_d       = gnt_wr_d ? bus.iWR_Y : bus.iRD_Y;
        calc_en_d = (state_q == S_IDLE) & gnt_any_d;
    end

    coord_addr_calc #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_calc (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .en_i        (calc_en_d),
        .x_i         (x_d),
        .y_i         (y_d),
        .addr_o      (calc_addr),
        .range_err_o (calc_err)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            dir_wr_q  <= 1'b0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            addr_q    <= '0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_rd_q <= 1'b1;
`endif
        end else begin
            ce_n_q   <= 1'b0;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_any_d) begin
                        dir_wr_q <= gnt_wr_d;
                        wdata_q  <= bus.iWR_DATA;
`ifdef SRAM_ARB_RR_EN
                        last_rd_q <= ~gnt_wr_d;
`endif
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (calc_err) begin
                        state_q <= S_IDLE;
                    end else if (dir_wr_q) begin
                        addr_q  <= calc_addr;
                        dq_oe_q <= 1'b1;
                        we_n_q  <= 1'b0;
                        state_q <= S_WR;
                    end else begin
                        addr_q  <= calc_addr;
                        oe_n_q  <= 1'b0;
                        state_q <= S_RD1;
                    end
                end
                S_WR: begin
                    we_n_q   <= 1'b1;
                    wr_ack_q <= 1'b1;
                    state_q  <= S_REC;
                end
                S_REC: begin
                    dq_oe_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_RD1: begin
                    state_q <= S_RD2;
                end
                S_RD2: begin
                    rd_data_q <= ioSRAM_DQ;
                    rd_ack_q  <= 1'b1;
                    oe_n_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign err_ack        = (state_q == S_CALC) & calc_err;
    assign bus.oWR_ACK    = wr_ack_q | (err_ack & dir_wr_q);
    assign bus.oRD_ACK    = rd_ack_q | (err_ack & ~dir_wr_q);
    assign bus.oRANGE_ERR = err_ack;
    assign bus.oRD_DATA   = rd_data_q;
    assign bus.oBUSY      = (state_q != S_IDLE);

    assign oSRAM_ADDR = addr_q;
    assign oSRAM_WE_N = we_n_q;
    assign oSRAM_OE_N = oe_n_q;
    assign oSRAM_CE_N = ce_n_q;
    assign oSRAM_LB_N = ce_n_q;
    assign oSRAM_UB_N = ce_n_q;
    assign ioSRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_coord_arbiter.sv
// Scoreboard bench for sram_coord_arbiter with an SRAM device model.
module tb_sram_coord_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_coord_arbiter_if #(.DATA_W(16)) bus ();

    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, lb_n, ub_n;

    sram_coord_arbiter #(
        .H_RES  (640),
        .V_RES  (480),
        .DATA_W (16)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .bus        (bus),
        .oSRAM_ADDR (sram_addr),
        .ioSRAM_DQ  (sram_dq),
        .oSRAM_WE_N (we_n),
        .oSRAM_OE_N (oe_n),
        .oSRAM_CE_N (ce_n),
        .oSRAM_LB_N (lb_n),
        .oSRAM_UB_N (ub_n)
    );

    // SRAM device
    logic [15:0] mem [0:1048575];
    assign sram_dq = (!oe_n) ? mem[sram_addr] : 16'hzzzz;

    typedef struct {
        bit          is_rd;
        bit          err;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          cyc;
    } stb_t;

    exp_t        expq[$];
    stb_t        stbq[$];
    logic [15:0] ref_mem [int];
    bit          last_rd = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Ack monitor
    always @(negedge clk) begin
        if (!rst && (bus.oWR_ACK || bus.oRD_ACK)) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=wr%0b/rd%0b required=none cyc=%0d",
                         bus.oWR_ACK, bus.oRD_ACK, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("ack_kind", {bus.oRD_ACK, bus.oWR_ACK}, e.is_rd ? 2'b10 : 2'b01);
                chk("ack_cycle", cyc, e.cyc);
                chk("range_err", bus.oRANGE_ERR, e.err);
                if (e.is_rd && !e.err) chk("rd_data", bus.oRD_DATA, e.data);
            end
        end
    end

    // Write-strobe monitor and SRAM write
    always @(negedge clk) begin
        if (!rst && !we_n) begin
            mem[sram_addr] = sram_dq;
            if (stbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=%0d required=none", sram_addr);
            end else begin
                stb_t s;
                s = stbq.pop_front();
                chk("we_addr", sram_addr, s.addr);
                chk("we_data", sram_dq, s.data);
                chk("we_cycle", cyc, s.cyc);
            end
        end
    end

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    // Reference: one served access; returns base of the next grant
    function automatic int model_op(input bit is_rd, input int x, input int y,
                                    input logic [15:0] d, input int base);
        exp_t e;
        stb_t s;
        int   a;
        e.is_rd = is_rd;
        e.err   = (x >= 640) || (y >= 480);
        a       = x + y * 640;
        e.data  = 16'h0;
        last_rd = is_rd;
        if (e.err) begin
            e.cyc = base + 1;
            expq.push_back(e);
            return base + 2;
        end
        if (is_rd) begin
            e.data = ref_rd(a);
            e.cyc  = base + 4;
        end else begin
            ref_mem[a] = d;
            s.addr = a;
            s.data = d;
            s.cyc  = base + 2;
            stbq.push_back(s);
            e.cyc = base + 3;
        end
        expq.push_back(e);
        return base + 4;
    endfunction

    task automatic do_op(input bit dw, input bit dr, input int wx, input int wy,
                         input logic [15:0] wd, input int rx, input int ry);
        int base;
        bit first_rd;
        bit pw, pr;
        base = cyc;
        bus.iWR_X    = 13'(wx);
        bus.iWR_Y    = 13'(wy);
        bus.iWR_DATA = wd;
        bus.iRD_X    = 13'(rx);
        bus.iRD_Y    = 13'(ry);
        bus.iWR_REQ  = dw;
        bus.iRD_REQ  = dr;
        if (dw && dr) begin
`ifdef SRAM_ARB_RR_EN
            first_rd = !last_rd;
`else
            first_rd = 1'b0;
`endif
        end else begin
            first_rd = dr;
        end
        if (first_rd) base = model_op(1'b1, rx, ry, 16'h0, base);
        else          base = model_op(1'b0, wx, wy, wd, base);
        if (dw && dr) begin
            if (first_rd) base = model_op(1'b0, wx, wy, wd, base);
            else          base = model_op(1'b1, rx, ry, 16'h0, base);
        end
        pw = dw;
        pr = dr;
        for (int k = 0; k < 40 && (pw || pr); k++) begin
            @(negedge clk);
            if (pw && bus.oWR_ACK) begin
                pw = 1'b0;
                bus.iWR_REQ = 1'b0;
            end
            if (pr && bus.oRD_ACK) begin
                pr = 1'b0;
                bus.iRD_REQ = 1'b0;
            end
        end
        if (pw || pr) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=pending wr%0b/rd%0b required=acked", pw, pr);
            bus.iWR_REQ = 1'b0;
            bus.iRD_REQ = 1'b0;
        end
        @(negedge clk);
    endtask

    function automatic int rnd_x();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 640 + int'($urandom_range(0, 3));
        if (r == 1) return 639;
        return int'($urandom_range(0, 7));
    endfunction

    function automatic int rnd_y();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 480 + int'($urandom_range(0, 3));
        if (r == 1) return 479;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        bit ok;
        for (int i = 0; i < 1048576; i++) mem[i] = 16'h0;
        bus.iWR_REQ  = 1'b0;
        bus.iRD_REQ  = 1'b0;
        bus.iWR_X    = '0;
        bus.iWR_Y    = '0;
        bus.iWR_DATA = '0;
        bus.iRD_X    = '0;
        bus.iRD_Y    = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ack", bus.oWR_ACK, 0);
        chk("rst_rd_ack", bus.oRD_ACK, 0);
        chk("rst_range", bus.oRANGE_ERR, 0);
        chk("rst_busy", bus.oBUSY, 0);
        chk("rst_rd_data", bus.oRD_DATA, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_ce_n", {ce_n, lb_n, ub_n}, 3'b111);
        rst = 1'b0;
        @(negedge clk);
        chk("run_ce_n", {ce_n, lb_n, ub_n}, 3'b000);

        do_op(1, 0, 3, 2, 16'hABCD, 0, 0);
        do_op(0, 1, 0, 0, 16'h0, 3, 2);
        do_op(1, 1, 5, 1, 16'h1111, 5, 1);
        do_op(1, 1, 6, 1, 16'h2222, 6, 1);
        do_op(1, 0, 640, 0, 16'h5555, 0, 0);
        do_op(0, 1, 0, 0, 16'h0, 0, 480);
        do_op(1, 0, 639, 479, 16'hBEEF, 0, 0);
        do_op(0, 1, 0, 0, 16'h0, 639, 479);

        // Reset in RD1: abort, no ack
        bus.iRD_X   = 13'd4;
        bus.iRD_Y   = 13'd1;
        bus.iRD_REQ = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (!oe_n) ok = 1'b1;
        end
        chk("rd1_reached", ok, 1);
        rst = 1'b1;
        bus.iRD_REQ = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.oBUSY, 0);
        chk("abort_oe_n", oe_n, 1);
        chk("abort_rd_ack", bus.oRD_ACK, 0);
        rst = 1'b0;
        last_rd = 1'b1;
        repeat (6) @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            int m;
            m = int'($urandom_range(0, 2));
            do_op(m != 1, m != 0, rnd_x(), rnd_y(), 16'($urandom),
                  rnd_x(), rnd_y());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("expq_drained", expq.size(), 0);
        chk("stbq_drained", stbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
